// File: rtl/rics_multicycle_ctrl_pkg.sv
// Shared encodings for the RICS multi-cycle control FSM: opcodes, mux select codes, state set.
package rics_multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_LW    = 4'h3;
  localparam logic [3:0] OP_SW    = 4'h4;
  localparam logic [3:0] OP_BEQ   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ALU_FUNC = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_OR   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

endpackage

// File: rtl/rics_multicycle_ctrl_perf_cnt.sv
// Cycle and retired-instruction counters for the RICS control FSM (built only with RICS_PERF_CNT_EN).
module rics_multicycle_ctrl_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             countCycle,
  input  logic             retire,
  output logic [CNT_W-1:0] instrCnt,
  output logic [CNT_W-1:0] cycleCnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrCnt <= '0;
      cycleCnt <= '0;
    end else begin
      if (retire)     instrCnt <= instrCnt + CNT_W'(1);
      if (countCycle) cycleCnt <= cycleCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rics_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RICS datapath.
// Optional perf counters are built when RICS_PERF_CNT_EN is defined.
module rics_multicycle_ctrl
  import rics_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             inp_clk,
  input  logic             inp_rst_n,
  input  logic [OPC_W-1:0] inp_opcode,
  input  logic             inp_zero,
  input  logic             inp_memReady,
  output logic             out_memRead,
  output logic             out_memWrite,
  output logic             out_iorD,
  output logic             out_irWrite,
  output logic             out_pcWrite,
  output logic             out_pcWriteCond,
  output logic [1:0]       out_pcSrc,
  output logic             out_aluSrcA,
  output logic [1:0]       out_aluSrcB,
  output logic [1:0]       out_aluOp,
  output logic             out_regWrite,
  output logic             out_regDst,
  output logic             out_memToReg,
  output logic             out_halted,
  output logic             out_illegal,
  output logic [CNT_W-1:0] out_instrCnt,
  output logic [CNT_W-1:0] out_cycleCnt
);

  state_e state, nextState;
  logic   illegalSet;

  // The zero flag gates the PC write inside the datapath; the FSM never needs it.
  logic unusedZero;
  assign unusedZero = inp_zero;

  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) state <= S_FETCH;
    else            state <= nextState;
  end

  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n)      out_illegal <= 1'b0;
    else if (illegalSet) out_illegal <= 1'b1;
  end

  // Outputs are forced low while reset is held, so a mid-instruction reset drops them at once.
  always_comb begin
    nextState       = state;
    illegalSet      = 1'b0;
    out_memRead     = 1'b0;
    out_memWrite    = 1'b0;
    out_iorD        = 1'b0;
    out_irWrite     = 1'b0;
    out_pcWrite     = 1'b0;
    out_pcWriteCond = 1'b0;
    out_pcSrc       = PC_ALU;
    out_aluSrcA     = 1'b0;
    out_aluSrcB     = SRCB_REGB;
    out_aluOp       = ALU_FUNC;
    out_regWrite    = 1'b0;
    out_regDst      = 1'b0;
    out_memToReg    = 1'b0;
    out_halted      = 1'b0;
    if (inp_rst_n) begin
      case (state)
        S_FETCH: begin
          out_memRead = 1'b1;
          out_aluSrcB = SRCB_ONE;
          out_aluOp   = ALU_ADD;
          out_irWrite = inp_memReady;
          out_pcWrite = inp_memReady;
          if (inp_memReady) nextState = S_DECODE;
        end
        S_DECODE: begin
          out_aluSrcB = SRCB_BROFF;
          out_aluOp   = ALU_ADD;
          case (inp_opcode)
            OPC_W'(OP_RTYPE): nextState = S_EXEC_R;
            OPC_W'(OP_ADDI),
            OPC_W'(OP_ORI):   nextState = S_EXEC_I;
            OPC_W'(OP_LW),
            OPC_W'(OP_SW):    nextState = S_MEM_ADDR;
            OPC_W'(OP_BEQ):   nextState = S_BRANCH;
            OPC_W'(OP_JMP):   nextState = S_JUMP;
            OPC_W'(OP_HALT):  nextState = S_HALT;
            default: begin
              nextState  = S_HALT;
              illegalSet = 1'b1;
            end
          endcase
        end
        S_EXEC_R: begin
          out_aluSrcA = 1'b1;
          nextState   = S_WB_R;
        end
        S_WB_R: begin
          out_regWrite = 1'b1;
          out_regDst   = 1'b1;
          nextState    = S_FETCH;
        end
        S_EXEC_I: begin
          out_aluSrcA = 1'b1;
          out_aluSrcB = SRCB_IMM;
          out_aluOp   = (inp_opcode == OPC_W'(OP_ORI)) ? ALU_OR : ALU_ADD;
          nextState   = S_WB_I;
        end
        S_WB_I: begin
          out_regWrite = 1'b1;
          nextState    = S_FETCH;
        end
        S_MEM_ADDR: begin
          out_aluSrcA = 1'b1;
          out_aluSrcB = SRCB_IMM;
          out_aluOp   = ALU_ADD;
          nextState   = (inp_opcode == OPC_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          out_memRead = 1'b1;
          out_iorD    = 1'b1;
          if (inp_memReady) nextState = S_WB_MEM;
        end
        S_WB_MEM: begin
          out_regWrite = 1'b1;
          out_memToReg = 1'b1;
          nextState    = S_FETCH;
        end
        S_MEM_WR: begin
          out_memWrite = 1'b1;
          out_iorD     = 1'b1;
          if (inp_memReady) nextState = S_FETCH;
        end
        S_BRANCH: begin
          out_aluSrcA     = 1'b1;
          out_aluOp       = ALU_SUB;
          out_pcWriteCond = 1'b1;
          out_pcSrc       = PC_ALUOUT;
          nextState       = S_FETCH;
        end
        S_JUMP: begin
          out_pcWrite = 1'b1;
          out_pcSrc   = PC_JUMP;
          nextState   = S_FETCH;
        end
        S_HALT: out_halted = 1'b1;
        default: nextState = S_FETCH;
      endcase
    end
  end

`ifdef RICS_PERF_CNT_EN
  logic countCycle, retire;
  assign countCycle = (state != S_HALT);
  assign retire     = (state != S_FETCH) && (nextState == S_FETCH);

  rics_multicycle_ctrl_perf_cnt #(
    .CNT_W(CNT_W)
  ) uPerfCnt (
    .clk       (inp_clk),
    .rst_n     (inp_rst_n),
    .countCycle(countCycle),
    .retire    (retire),
    .instrCnt  (out_instrCnt),
    .cycleCnt  (out_cycleCnt)
  );
`else
  assign out_instrCnt = '0;
  assign out_cycleCnt = '0;
`endif

endmodule

// File: tb/tb_rics_multicycle_ctrl.sv
// Bench for rics_multicycle_ctrl: directed vector table plus random programs against a per-instruction model.
`timescale 1ns/1ps
module tb_rics_multicycle_ctrl;

  localparam int unsigned CNT_W = 32;
`ifdef RICS_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic       memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond;
    logic [1:0] pcSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       regWrite, regDst, memToReg, halted, illegal;
  } ctrl_t;

  typedef enum {
    P_ZERO, P_FETCH_W, P_FETCH, P_DECODE, P_EXEC_R, P_WB_R, P_EXEC_ADD, P_EXEC_OR,
    P_WB_I, P_ADDR, P_RD, P_WB_MEM, P_WR, P_BRANCH, P_JUMP, P_HALT, P_ILL
  } phase_e;

  typedef struct {
    logic       rstN;
    logic [3:0] op;
    logic       zero;
    logic       mr;
    phase_e     ph;
  } vec_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [3:0] opcode = '0;
  logic zero = 1'b0;
  logic memReady = 1'b0;
  logic memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond, aluSrcA;
  logic regWrite, regDst, memToReg, halted, illegal;
  logic [1:0] pcSrc, aluSrcB, aluOp;
  logic [CNT_W-1:0] instrCnt, cycleCnt;
  ctrl_t got;

  int total = 0;
  int bad = 0;
  vec_t dir[$];
  logic [3:0] prog[$];

  always #5 clk = ~clk;

  rics_multicycle_ctrl #(.OPC_W(4), .CNT_W(CNT_W)) dut (
    .inp_clk(clk), .inp_rst_n(rstN), .inp_opcode(opcode), .inp_zero(zero),
    .inp_memReady(memReady), .out_memRead(memRead), .out_memWrite(memWrite),
    .out_iorD(iorD), .out_irWrite(irWrite), .out_pcWrite(pcWrite),
    .out_pcWriteCond(pcWriteCond), .out_pcSrc(pcSrc), .out_aluSrcA(aluSrcA),
    .out_aluSrcB(aluSrcB), .out_aluOp(aluOp), .out_regWrite(regWrite),
    .out_regDst(regDst), .out_memToReg(memToReg), .out_halted(halted),
    .out_illegal(illegal), .out_instrCnt(instrCnt), .out_cycleCnt(cycleCnt)
  );

  assign got = {memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond, pcSrc, aluSrcA,
                aluSrcB, aluOp, regWrite, regDst, memToReg, halted, illegal};

  // Expected control word for each phase of an instruction.
  function automatic ctrl_t expOf(phase_e p);
    ctrl_t c = '0;
    case (p)
      P_FETCH_W, P_FETCH: begin
        c.memRead = 1'b1; c.aluSrcB = 2'b01; c.aluOp = 2'b01;
        if (p == P_FETCH) begin c.irWrite = 1'b1; c.pcWrite = 1'b1; end
      end
      P_DECODE:   begin c.aluSrcB = 2'b11; c.aluOp = 2'b01; end
      P_EXEC_R:   c.aluSrcA = 1'b1;
      P_WB_R:     begin c.regWrite = 1'b1; c.regDst = 1'b1; end
      P_EXEC_ADD: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = 2'b01; end
      P_EXEC_OR:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = 2'b11; end
      P_WB_I:     c.regWrite = 1'b1;
      P_ADDR:     begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = 2'b01; end
      P_RD:       begin c.memRead = 1'b1; c.iorD = 1'b1; end
      P_WB_MEM:   begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
      P_WR:       begin c.memWrite = 1'b1; c.iorD = 1'b1; end
      P_BRANCH:   begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; c.pcWriteCond = 1'b1; c.pcSrc = 2'b01; end
      P_JUMP:     begin c.pcWrite = 1'b1; c.pcSrc = 2'b10; end
      P_HALT:     c.halted = 1'b1;
      P_ILL:      begin c.halted = 1'b1; c.illegal = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic vec_t v(logic r, logic [3:0] op, logic z, logic mr, phase_e ph);
    vec_t x;
    x.rstN = r; x.op = op; x.zero = z; x.mr = mr; x.ph = ph;
    return x;
  endfunction

  task automatic drive(input vec_t s);
    rstN = s.rstN; opcode = s.op; zero = s.zero; memReady = s.mr;
  endtask

  task automatic checkCtrl(input string name, input ctrl_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: ctrl got=%b required=%b", name, got, exp);
    end
  endtask

  task automatic checkCnt(input string name, input int expI, input int expC);
    logic [CNT_W-1:0] eI, eC;
    eI = PERF ? CNT_W'(expI) : '0;
    eC = PERF ? CNT_W'(expC) : '0;
    total++;
    if (instrCnt !== eI) begin
      bad++;
      $display("FAIL %s: instrCnt got=%0d required=%0d", name, instrCnt, eI);
    end
    total++;
    if (cycleCnt !== eC) begin
      bad++;
      $display("FAIL %s: cycleCnt got=%0d required=%0d", name, cycleCnt, eC);
    end
  endtask

  // Runs prog[] from a fresh reset; expectations come from expanding each opcode into its phase list.
  task automatic runProgram(input bit randWaits, input string tag);
    vec_t st[$];
    int k = 0;
    int retired = 0;
    int haltK = -1;
    int w;
    phase_e ph;
    drive(v(1'b0, 4'h0, 1'b0, 1'b1, P_ZERO));
    @(negedge clk);
    checkCtrl({tag, "_reset"}, '0);
    checkCnt({tag, "_reset"}, 0, 0);
    @(posedge clk); #1;
    foreach (prog[i]) begin
      logic [3:0] op = prog[i];
      bit stops = 1'b0;
      st.delete();
      w = randWaits ? $urandom_range(0, 2) : 0;
      repeat (w) st.push_back(v(1'b1, 4'($urandom), 1'($urandom), 1'b0, P_FETCH_W));
      st.push_back(v(1'b1, 4'($urandom), 1'($urandom), 1'b1, P_FETCH));
      st.push_back(v(1'b1, op, 1'($urandom), 1'($urandom), P_DECODE));
      w = randWaits ? $urandom_range(0, 3) : 0;
      case (op)
        4'h0: begin st.push_back(v(1'b1, op, 1'($urandom), 1'($urandom), P_EXEC_R));
                    st.push_back(v(1'b1, op, 1'($urandom), 1'($urandom), P_WB_R)); end
        4'h1, 4'h2: begin
          st.push_back(v(1'b1, op, 1'($urandom), 1'($urandom), (op == 4'h2) ? P_EXEC_OR : P_EXEC_ADD));
          st.push_back(v(1'b1, op, 1'($urandom), 1'($urandom), P_WB_I));
        end
        4'h3, 4'h4: begin
          ph = (op == 4'h3) ? P_RD : P_WR;
          st.push_back(v(1'b1, op, 1'($urandom), 1'($urandom), P_ADDR));
          repeat (w) st.push_back(v(1'b1, op, 1'($urandom), 1'b0, ph));
          st.push_back(v(1'b1, op, 1'($urandom), 1'b1, ph));
          if (op == 4'h3) st.push_back(v(1'b1, op, 1'($urandom), 1'($urandom), P_WB_MEM));
        end
        4'h5: st.push_back(v(1'b1, op, 1'($urandom), 1'($urandom), P_BRANCH));
        4'h6: st.push_back(v(1'b1, op, 1'($urandom), 1'($urandom), P_JUMP));
        default: begin
          stops = 1'b1;
          repeat (3) st.push_back(v(1'b1, op, 1'($urandom), 1'($urandom),
                                    (op == 4'hF) ? P_HALT : P_ILL));
        end
      endcase
      foreach (st[j]) begin
        drive(st[j]);
        if ((st[j].ph == P_HALT || st[j].ph == P_ILL) && haltK < 0) haltK = k;
        @(negedge clk);
        checkCtrl($sformatf("%s_i%0d_%s", tag, i, st[j].ph.name()), expOf(st[j].ph));
        checkCnt($sformatf("%s_i%0d_%s", tag, i, st[j].ph.name()), retired,
                 (haltK >= 0) ? haltK : k);
        @(posedge clk); #1;
        k++;
      end
      if (stops) break;
      retired++;
    end
  endtask

  initial begin
    // Directed table: RTYPE, LW with 3 waits, BEQ, ORI, reset mid-SW, illegal opcode.
    dir.push_back(v(1'b0, 4'h0, 1'b0, 1'b0, P_ZERO));
    dir.push_back(v(1'b1, 4'h0, 1'b0, 1'b1, P_FETCH));
    dir.push_back(v(1'b1, 4'h0, 1'b0, 1'b0, P_DECODE));
    dir.push_back(v(1'b1, 4'h0, 1'b0, 1'b0, P_EXEC_R));
    dir.push_back(v(1'b1, 4'h0, 1'b0, 1'b0, P_WB_R));
    dir.push_back(v(1'b1, 4'h3, 1'b0, 1'b0, P_FETCH_W));
    dir.push_back(v(1'b1, 4'h3, 1'b0, 1'b1, P_FETCH));
    dir.push_back(v(1'b1, 4'h3, 1'b0, 1'b0, P_DECODE));
    dir.push_back(v(1'b1, 4'h3, 1'b0, 1'b1, P_ADDR));
    repeat (3) dir.push_back(v(1'b1, 4'h3, 1'b0, 1'b0, P_RD));
    dir.push_back(v(1'b1, 4'h3, 1'b0, 1'b1, P_RD));
    dir.push_back(v(1'b1, 4'h3, 1'b0, 1'b0, P_WB_MEM));
    dir.push_back(v(1'b1, 4'h5, 1'b1, 1'b1, P_FETCH));
    dir.push_back(v(1'b1, 4'h5, 1'b1, 1'b0, P_DECODE));
    dir.push_back(v(1'b1, 4'h5, 1'b1, 1'b0, P_BRANCH));
    dir.push_back(v(1'b1, 4'h2, 1'b0, 1'b1, P_FETCH));
    dir.push_back(v(1'b1, 4'h2, 1'b0, 1'b0, P_DECODE));
    dir.push_back(v(1'b1, 4'h2, 1'b0, 1'b0, P_EXEC_OR));
    dir.push_back(v(1'b1, 4'h2, 1'b0, 1'b0, P_WB_I));
    dir.push_back(v(1'b1, 4'h4, 1'b0, 1'b1, P_FETCH));
    dir.push_back(v(1'b1, 4'h4, 1'b0, 1'b0, P_DECODE));
    dir.push_back(v(1'b1, 4'h4, 1'b0, 1'b0, P_ADDR));
    repeat (2) dir.push_back(v(1'b1, 4'h4, 1'b0, 1'b0, P_WR));
    dir.push_back(v(1'b0, 4'h4, 1'b0, 1'b1, P_ZERO));
    dir.push_back(v(1'b1, 4'h4, 1'b0, 1'b0, P_FETCH_W));
    dir.push_back(v(1'b1, 4'hA, 1'b0, 1'b1, P_FETCH));
    dir.push_back(v(1'b1, 4'hA, 1'b0, 1'b1, P_DECODE));
    repeat (3) dir.push_back(v(1'b1, 4'hA, 1'b0, 1'b1, P_ILL));
    dir.push_back(v(1'b0, 4'h0, 1'b0, 1'b0, P_ZERO));
    dir.push_back(v(1'b1, 4'h0, 1'b0, 1'b0, P_FETCH_W));

    #1;
    foreach (dir[i]) begin
      drive(dir[i]);
      @(negedge clk);
      checkCtrl($sformatf("dir%0d_%s", i, dir[i].ph.name()), expOf(dir[i].ph));
      if (!dir[i].rstN) checkCnt($sformatf("dir%0d_reset", i), 0, 0);
      @(posedge clk); #1;
    end

    // Three RTYPE then HALT with zero-wait memory.
    prog = '{4'h0, 4'h0, 4'h0, 4'hF};
    runProgram(1'b0, "perf");

    for (int r = 0; r < 4; r++) begin
      prog.delete();
      repeat (40) prog.push_back(4'($urandom_range(0, 6)));
      prog.push_back($urandom_range(0, 1) ? 4'hF : 4'($urandom_range(7, 14)));
      runProgram(1'b1, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
